// File: rtl/ann_weight_pkg.sv
// Shared constants and FSM state type for the weight BRAM read sequencer.
package ann_weight_pkg;

  localparam int unsigned W_DW    = 16;
  localparam int unsigned W_AW    = 5;
  localparam int unsigned W_DEPTH = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/weight_skid_buf.sv
// Two-entry valid/ready buffer carrying {last, index, data} from the BRAM
// capture point to the MAC. The writer must never push into a full buffer.
module weight_skid_buf #(
  parameter int unsigned PW = 22
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [PW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [PW-1:0] o_data,
  output logic [1:0]    o_count
);

  logic [1:0][PW-1:0] r_mem;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_pop;

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/weight_bram_reader.sv
// Walks a wrapping address window of the per-neuron weight BRAM and streams
// each weight to the MAC. Optional stall counter: WEIGHT_BRAM_READER_STALL_CNT_EN.
module weight_bram_reader
  import ann_weight_pkg::*;
#(
  parameter int unsigned DW    = W_DW,
  parameter int unsigned AW    = W_AW,
  parameter int unsigned DEPTH = W_DEPTH
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] BASE,
  input  logic [AW:0]   COUNT,
  output logic          BUSY,
  output logic          DONE,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  output logic [AW-1:0] BRAM_ADDR,
  input  logic [DW-1:0] BRAM_DO,
  output logic [DW-1:0] W_DATA,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic          W_LAST,
  output logic [AW-1:0] W_IDX
`ifdef WEIGHT_BRAM_READER_STALL_CNT_EN
  ,
  output logic [15:0]   STALL_CNT
`endif
);

  localparam int unsigned PW            = DW + AW + 1;
  localparam logic [AW:0]   LP_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_ONE       = (AW+1)'(1);
  localparam logic [AW-1:0] LP_LAST_ADDR = AW'(DEPTH - 1);

  rd_state_e     r_state;
  rd_state_e     w_state_nxt;

  logic          r_en;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_next_addr;
  logic [AW:0]   r_rem;
  logic [AW-1:0] r_issue_idx;
  logic [AW-1:0] r_tag_idx;
  logic          r_tag_last;

  logic [AW-1:0] w_base_mod;
  logic [AW:0]   w_count_clamp;
  logic          w_start_acc;
  logic          w_pop;
  logic          w_issue;
  logic [1:0]    w_occ;
  logic [1:0]    w_occ_after;
  logic [PW-1:0] w_buf_out;

  assign w_base_mod    = AW'({1'b0, BASE} % LP_DEPTH);
  assign w_count_clamp = (COUNT > LP_DEPTH) ? LP_DEPTH : COUNT;
  assign w_start_acc   = (r_state == IDLE) && START;
  assign w_pop         = W_VALID && W_READY;
  assign w_occ_after   = w_occ - {1'b0, w_pop};

  // r_en marks the read whose data lands in the buffer at this edge, so it
  // counts as already occupying a slot when deciding the next issue.
  assign w_issue = (r_state == RUN) && (r_rem != '0) &&
                   ((3'(w_occ_after) + 3'(r_en)) <= 3'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_state_nxt = (w_count_clamp == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (w_issue && (r_rem == LP_ONE)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_en && (w_occ_after == 2'd0)) begin
          w_state_nxt = FIN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign BUSY = (r_state != IDLE);
  assign DONE = (r_state == FIN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_en        <= 1'b0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_rem       <= '0;
      r_issue_idx <= '0;
      r_tag_idx   <= '0;
      r_tag_last  <= 1'b0;
    end else begin
      r_en <= w_issue;
      if (w_start_acc) begin
        r_next_addr <= w_base_mod;
        r_rem       <= w_count_clamp;
        r_issue_idx <= '0;
      end else if (w_issue) begin
        r_addr      <= r_next_addr;
        r_next_addr <= (r_next_addr == LP_LAST_ADDR) ? '0 : r_next_addr + 1'b1;
        r_rem       <= r_rem - 1'b1;
        r_issue_idx <= r_issue_idx + 1'b1;
        r_tag_idx   <= r_issue_idx;
        r_tag_last  <= (r_rem == LP_ONE);
      end
    end
  end

  assign BRAM_EN   = r_en;
  assign BRAM_WE   = 1'b0;
  assign BRAM_ADDR = r_addr;

  weight_skid_buf #(
    .PW (PW)
  ) u_skid (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (r_en),
    .i_data  ({r_tag_last, r_tag_idx, BRAM_DO}),
    .i_ready (W_READY),
    .o_valid (W_VALID),
    .o_data  (w_buf_out),
    .o_count (w_occ)
  );

  assign W_DATA = w_buf_out[DW-1:0];
  assign W_IDX  = w_buf_out[DW +: AW];
  assign W_LAST = w_buf_out[PW-1];

`ifdef WEIGHT_BRAM_READER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (W_VALID && !W_READY && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign STALL_CNT = r_stall_cnt;
`endif

endmodule

// File: tb/tb_weight_bram_reader.sv
// Directed bench for weight_bram_reader with a falling-edge BRAM model and a
// scoreboard of expected read addresses and beats.
module tb_weight_bram_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [4:0]  BASE = '0;
  logic [5:0]  COUNT = '0;
  logic        BUSY, DONE, BRAM_EN, BRAM_WE;
  logic [4:0]  BRAM_ADDR;
  logic [15:0] BRAM_DO = '0;
  logic [15:0] W_DATA;
  logic        W_VALID;
  logic        W_READY = 1'b1;
  logic        W_LAST;
  logic [4:0]  W_IDX;
`ifdef WEIGHT_BRAM_READER_STALL_CNT_EN
  logic [15:0] STALL_CNT;
`endif

  weight_bram_reader #(.DW(16), .AW(5), .DEPTH(28)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .COUNT(COUNT),
    .BUSY(BUSY), .DONE(DONE), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_DO(BRAM_DO), .W_DATA(W_DATA),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_LAST(W_LAST), .W_IDX(W_IDX)
`ifdef WEIGHT_BRAM_READER_STALL_CNT_EN
    , .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  idx;
    logic        last;
  } beat_t;

  logic [15:0] mem [28];
  beat_t       exp_q[$];
  int          addr_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          issued = 0, accepted = 0, acc_cnt = 0, stall_m = 0;
  int          first_valid_cyc = -1, last_acc_cyc = -1, start_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [21:0] prev_beat = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (BRAM_EN) BRAM_DO <= mem[BRAM_ADDR];
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: reads and beats are compared in order of appearance.
  always @(negedge CLK) begin
    if (!RST) begin
      if (BRAM_EN) begin
        issued++;
        chk("bram_we", 32'(BRAM_WE), 32'd0);
        if (addr_q.size() == 0) chk("spurious_read", 32'(BRAM_ADDR), 32'hFFFF_FFFF);
        else chk("bram_addr", 32'(BRAM_ADDR), 32'(addr_q.pop_front()));
        chk("outstanding_le2", 32'(issued - accepted <= 2), 32'd1);
      end
      if (W_VALID && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) chk("stall_hold", {10'd0, W_VALID, W_LAST, W_IDX, W_DATA}, {10'd0, 1'b1, prev_beat});
      if (W_VALID && W_READY) begin
        beat_t e;
        accepted++;
        acc_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_beat", {16'd0, W_DATA}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("w_data", 32'(W_DATA), 32'(e.d));
          chk("w_idx", 32'(W_IDX), 32'(e.idx));
          chk("w_last", 32'(W_LAST), 32'(e.last));
        end
        if (W_LAST) last_acc_cyc = cyc;
      end
      if (W_VALID && !W_READY) stall_m++;
      prev_stall = W_VALID && !W_READY;
      prev_beat  = {W_LAST, W_IDX, W_DATA};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(BUSY), 32'd0);
    chk({tag, "_done"},  32'(DONE), 32'd0);
    chk({tag, "_en"},    32'(BRAM_EN), 32'd0);
    chk({tag, "_addr"},  32'(BRAM_ADDR), 32'd0);
    chk({tag, "_valid"}, 32'(W_VALID), 32'd0);
    chk({tag, "_last"},  32'(W_LAST), 32'd0);
    chk({tag, "_idx"},   32'(W_IDX), 32'd0);
    chk({tag, "_data"},  32'(W_DATA), 32'd0);
  endtask

  task automatic expect_walk(input int base, input int count);
    int b, n, a;
    b = base % 28;
    n = (count > 28) ? 28 : count;
    for (int i = 0; i < n; i++) begin
      a = (b + i) % 28;
      addr_q.push_back(a);
      exp_q.push_back(beat_t'{16'(100 + a), 5'(i), (i == n - 1)});
    end
    issued = 0; accepted = 0; acc_cnt = 0; stall_m = 0;
    first_valid_cyc = -1; last_acc_cyc = -1;
  endtask

  // pat 0: ready always high; pat 1: ready 1,0,0 repeating.
  task automatic run_walk(input int base, input int count, input int pat, input bit poke_start);
    int  n, k;
    bit  done_seen;
    n = (count > 28) ? 28 : count;
    expect_walk(base, count);
    START = 1'b1; BASE = 5'(base); COUNT = 6'(count); W_READY = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    start_cyc = cyc;
    chk("busy_on_accept", 32'(BUSY), 32'd1);
    k = 0;
    done_seen = 1'b0;
    while (!done_seen && k < 400) begin
      if (DONE) begin
        done_seen = 1'b1;
      end else begin
        if (poke_start && k == 4) begin
          START = 1'b1; BASE = 5'd10; COUNT = 6'd2;
        end else begin
          START = 1'b0;
        end
        W_READY = (pat == 0) ? 1'b1 : ((k % 3) == 0);
        @(posedge CLK); #1;
        k++;
      end
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    if (done_seen) begin
      if (n == 0) begin
        chk("done_latency_zero", 32'(k), 32'd0);
      end else begin
        chk("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd2);
        chk("done_after_last", 32'(cyc), 32'(last_acc_cyc + 1));
        if (pat == 0) chk("throughput", 32'(last_acc_cyc - first_valid_cyc), 32'(n - 1));
      end
      chk("busy_in_done", 32'(BUSY), 32'd1);
      chk("beats_left", 32'(exp_q.size()), 32'd0);
      chk("reads_left", 32'(addr_q.size()), 32'd0);
      chk("reads_issued", 32'(issued), 32'(n));
`ifdef WEIGHT_BRAM_READER_STALL_CNT_EN
      chk("stall_cnt", 32'(STALL_CNT), 32'(stall_m));
`endif
      if (poke_start) begin
        START = 1'b1; BASE = 5'd0; COUNT = 6'd5;
      end
      @(posedge CLK); #1;
      START = 1'b0;
      chk("done_pulse_one", 32'(DONE), 32'd0);
      chk("busy_cleared", 32'(BUSY), 32'd0);
      @(posedge CLK); #1;
      chk("start_in_done_ignored", 32'(BUSY), 32'd0);
    end
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 28; i++) mem[i] = 16'(100 + i);
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("reset");
    RST = 1'b0;
    @(posedge CLK); #1;

    run_walk(0, 28, 0, 1'b1);
    run_walk(26, 4, 0, 1'b0);
    run_walk(3, 6, 1, 1'b0);
    run_walk(0, 0, 0, 1'b0);
    run_walk(0, 31, 0, 1'b0);
    run_walk(30, 3, 1, 1'b0);

    expect_walk(0, 10);
    START = 1'b1; BASE = 5'd0; COUNT = 6'd10; W_READY = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    guard = 0;
    while (acc_cnt < 3 && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
    end
    chk("abort_reached_beat2", 32'(acc_cnt >= 3), 32'd1);
    RST = 1'b1;
    #1;
    chk_reset_outputs("abort");
    exp_q.delete();
    addr_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("abort_no_done", 32'(DONE), 32'd0);
      chk("abort_idle", 32'(BUSY), 32'd0);
    end

    run_walk(5, 3, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
